// File: rtl/sa_loader_ctrl.sv
// ---------------------------------------------------------------------------
// sa_loader_ctrl
//
// Sequencing controller for the systolic-array data-loader top. One start
// pulse runs a complete sequence:
//   weight preload -> mode switch -> one feature pass per output tile
//   -> drain of the loader's 3-stage c_sel delay line -> one-cycle done.
// Every output is a register, so the loader sees glitch-free controls that
// change only on clock edges.
//
// Parameters
//   NUM_TILES     number of feature passes / output registers (1..8)
//   FEAT_BASE0    feature base address of tile 0
//   FEAT_STRIDE   base-address step per tile (wraps modulo 64)
//   DRAIN_CYCLES  cycles waited after the last feature pass (>= 1)
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   start                one-cycle request, ignored while busy
//   abort                synchronous cancel, overrides every other input
//   is_WL_done_i         weight preloader finished (looked at in W_LOAD only)
//   is_FL_done_i         feature loader finished (looked at in F_LOAD only)
//   Weight_Preloader_en  high for the whole weight-preload pass
//   Feature_Loader_en    high for each feature pass
//   mode                 RAM address mux select, 0 = weight, 1 = feature
//   feature_baseaddr     feature base address of the current tile
//   c_sel                result-register select of the current tile
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse at the end of a sequence
// ---------------------------------------------------------------------------
module sa_loader_ctrl #(
   parameter int unsigned NUM_TILES    = 4,
   parameter logic [5:0]  FEAT_BASE0   = 6'd9,
   parameter logic [5:0]  FEAT_STRIDE  = 6'd3,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       is_WL_done_i,
   input  logic       is_FL_done_i,
   output logic       Weight_Preloader_en,
   output logic       Feature_Loader_en,
   output logic       mode,
   output logic [5:0] feature_baseaddr,
   output logic [2:0] c_sel,
   output logic       busy,
   output logic       done
);

   localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [2:0]        TILE_LAST  = 3'(NUM_TILES - 1);
   localparam logic [2:0]        TILE_ONE   = 3'd1;
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);
   localparam logic [DCNT_W-1:0] DCNT_ZERO  = '0;
   localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_LOAD,
      S_SWITCH,
      S_F_LOAD,
      S_F_NEXT,
      S_DRAIN,
      S_DONE
   } state_t;

   // Registered state and outputs
   state_t            r_state;
   logic [2:0]        r_tile;
   logic [DCNT_W-1:0] r_dcnt;
   logic              r_wp_en;
   logic              r_fl_en;
   logic              r_mode;
   logic [5:0]        r_base;
   logic [2:0]        r_csel;
   logic              r_busy;
   logic              r_done;

   // Next-state values
   state_t            w_state;
   logic [2:0]        w_tile;
   logic [DCNT_W-1:0] w_dcnt;
   logic              w_wp_en;
   logic              w_fl_en;
   logic              w_mode;
   logic [5:0]        w_base;
   logic [2:0]        w_csel;
   logic              w_busy;
   logic              w_done;

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state = r_state;
      w_tile  = r_tile;
      w_dcnt  = r_dcnt;
      w_wp_en = r_wp_en;
      w_fl_en = r_fl_en;
      w_mode  = r_mode;
      w_base  = r_base;
      w_csel  = r_csel;
      w_busy  = r_busy;
      w_done  = r_done;

      if (abort) begin
         // Cancel without a done pulse; base address and c_sel keep their
         // values, the next run reloads them at the weight-done edge.
         w_state = S_IDLE;
         w_wp_en = 1'b0;
         w_fl_en = 1'b0;
         w_mode  = 1'b0;
         w_busy  = 1'b0;
         w_done  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_state = S_W_LOAD;
                  w_wp_en = 1'b1;
                  w_mode  = 1'b0;
                  w_busy  = 1'b1;
                  w_done  = 1'b0;
               end
            end

            S_W_LOAD: begin
               if (is_WL_done_i) begin
                  w_state = S_SWITCH;
                  w_wp_en = 1'b0;
                  w_mode  = 1'b1;
                  w_tile  = '0;
                  w_base  = FEAT_BASE0;
                  w_csel  = '0;
               end
            end

            // One idle cycle so the loader's registered mode copy settles
            // before the first feature pass starts.
            S_SWITCH: begin
               w_state = S_F_LOAD;
               w_fl_en = 1'b1;
            end

            S_F_LOAD: begin
               if (is_FL_done_i) begin
                  w_fl_en = 1'b0;
                  if (r_tile < TILE_LAST) begin
                     w_state = S_F_NEXT;
                     w_tile  = r_tile + TILE_ONE;
                     w_base  = r_base + FEAT_STRIDE;
                     w_csel  = r_tile + TILE_ONE;
                  end else begin
                     w_state = S_DRAIN;
                     w_dcnt  = DCNT_ZERO;
                  end
               end
            end

            // Enable low for one cycle makes the loader restart its pass.
            S_F_NEXT: begin
               w_state = S_F_LOAD;
               w_fl_en = 1'b1;
            end

            // Let the last c_sel propagate through the loader's delay line.
            S_DRAIN: begin
               if (r_dcnt == DRAIN_LAST) begin
                  w_state = S_DONE;
                  w_done  = 1'b1;
               end else begin
                  w_dcnt = r_dcnt + DCNT_ONE;
               end
            end

            S_DONE: begin
               w_state = S_IDLE;
               w_done  = 1'b0;
               w_busy  = 1'b0;
               w_mode  = 1'b0;
            end

            default: begin
               w_state = S_IDLE;
               w_wp_en = 1'b0;
               w_fl_en = 1'b0;
               w_mode  = 1'b0;
               w_busy  = 1'b0;
               w_done  = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tile  <= '0;
         r_dcnt  <= '0;
         r_wp_en <= 1'b0;
         r_fl_en <= 1'b0;
         r_mode  <= 1'b0;
         r_base  <= FEAT_BASE0;
         r_csel  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_tile  <= w_tile;
         r_dcnt  <= w_dcnt;
         r_wp_en <= w_wp_en;
         r_fl_en <= w_fl_en;
         r_mode  <= w_mode;
         r_base  <= w_base;
         r_csel  <= w_csel;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign Weight_Preloader_en = r_wp_en;
   assign Feature_Loader_en   = r_fl_en;
   assign mode                = r_mode;
   assign feature_baseaddr    = r_base;
   assign c_sel               = r_csel;
   assign busy                = r_busy;
   assign done                = r_done;

endmodule

// File: tb/tb_sa_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sa_loader_ctrl
//
// Three controller instances: default parameters, a base address that wraps
// past 63, and a single-tile configuration. Each sequence is driven as a
// transaction and the expected outputs follow from the sequence rules:
// tile t uses base (BASE0 + t*STRIDE) mod 64 and c_sel t, done appears
// DRAIN cycles after the final feature-done edge, and so on.
// ---------------------------------------------------------------------------
module tb_sa_loader_ctrl;

   localparam int NT    [3] = '{4, 4, 1};
   localparam int BASE0 [3] = '{9, 62, 9};
   localparam int STRIDE    = 3;
   localparam int DRAIN     = 3;

   logic       clk;
   logic       rst;
   logic [2:0] start_v;
   logic [2:0] abort_v;
   logic [2:0] wl_v;
   logic [2:0] fl_v;
   logic [2:0] wp_o;
   logic [2:0] fe_o;
   logic [2:0] mode_o;
   logic [5:0] base_o [3];
   logic [2:0] csel_o [3];
   logic [2:0] busy_o;
   logic [2:0] done_o;

   int n_cmp = 0;
   int n_err = 0;

   // expected outputs of the instance under test
   int e_wp, e_fl, e_mode, e_busy, e_done;
   int e_base [3];
   int e_csel [3];

   sa_loader_ctrl #(.NUM_TILES(4), .FEAT_BASE0(6'd9), .FEAT_STRIDE(6'd3), .DRAIN_CYCLES(3)) u_def (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
      .is_WL_done_i(wl_v[0]), .is_FL_done_i(fl_v[0]),
      .Weight_Preloader_en(wp_o[0]), .Feature_Loader_en(fe_o[0]), .mode(mode_o[0]),
      .feature_baseaddr(base_o[0]), .c_sel(csel_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   sa_loader_ctrl #(.NUM_TILES(4), .FEAT_BASE0(6'd62), .FEAT_STRIDE(6'd3), .DRAIN_CYCLES(3)) u_wrap (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
      .is_WL_done_i(wl_v[1]), .is_FL_done_i(fl_v[1]),
      .Weight_Preloader_en(wp_o[1]), .Feature_Loader_en(fe_o[1]), .mode(mode_o[1]),
      .feature_baseaddr(base_o[1]), .c_sel(csel_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   sa_loader_ctrl #(.NUM_TILES(1), .FEAT_BASE0(6'd9), .FEAT_STRIDE(6'd3), .DRAIN_CYCLES(3)) u_one (
      .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
      .is_WL_done_i(wl_v[2]), .is_FL_done_i(fl_v[2]),
      .Weight_Preloader_en(wp_o[2]), .Feature_Loader_en(fe_o[2]), .mode(mode_o[2]),
      .feature_baseaddr(base_o[2]), .c_sel(csel_o[2]), .busy(busy_o[2]), .done(done_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input int d, input string tag);
      chk({tag, ".wp_en"}, 32'(wp_o[d]), 32'(e_wp));
      chk({tag, ".fl_en"}, 32'(fe_o[d]), 32'(e_fl));
      chk({tag, ".mode"},  32'(mode_o[d]), 32'(e_mode));
      chk({tag, ".base"},  32'(base_o[d]), 32'(e_base[d]));
      chk({tag, ".c_sel"}, 32'(csel_o[d]), 32'(e_csel[d]));
      chk({tag, ".busy"},  32'(busy_o[d]), 32'(e_busy));
      chk({tag, ".done"},  32'(done_o[d]), 32'(e_done));
      chk({tag, ".excl"},  32'(wp_o[d] & fe_o[d]), 32'd0);
   endtask

   task automatic set_idle();
      e_wp = 0; e_fl = 0; e_mode = 0; e_busy = 0; e_done = 0;
   endtask

   // One full sequence on instance d.
   //   wlw/flw    : hold cycles before the done input (negative = random)
   //   abort_tile : tile whose feature pass is aborted (-1 = none)
   //   rst_drain  : 1 = pulse rst in the middle of DRAIN
   task automatic run_seq(input int d, input int wlw, input int flw,
                          input int abort_tile, input int rst_drain);
      int w;
      // stray feature-done in IDLE does nothing
      fl_v[d] = 1'b1;
      tick();
      fl_v[d] = 1'b0;
      chk_all(d, "idle_stray");

      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      e_busy = 1; e_wp = 1; e_mode = 0;
      chk_all(d, "start");

      w = (wlw < 0) ? int'($urandom_range(0, 6)) : wlw;
      for (int i = 0; i < w; i++) begin
         fl_v[d]    = 1'($urandom_range(0, 1));
         start_v[d] = 1'($urandom_range(0, 1));
         tick();
         chk_all(d, "wload_hold");
      end
      fl_v[d] = 1'b0; start_v[d] = 1'b0;

      wl_v[d] = 1'b1;
      tick();
      wl_v[d] = 1'b0;
      e_wp = 0; e_mode = 1; e_base[d] = BASE0[d]; e_csel[d] = 0;
      chk_all(d, "wl_done");

      fl_v[d] = 1'($urandom_range(0, 1));
      tick();
      fl_v[d] = 1'b0;
      e_fl = 1;
      chk_all(d, "switch");

      for (int t = 0; t < NT[d]; t++) begin
         if (t == abort_tile) begin
            repeat (2) begin
               tick();
               chk_all(d, "pre_abort");
            end
            abort_v[d] = 1'b1;
            start_v[d] = 1'b1;
            tick();
            set_idle();
            chk_all(d, "abort");
            // start together with abort in IDLE is ignored
            tick();
            chk_all(d, "abort_start");
            abort_v[d] = 1'b0;
            start_v[d] = 1'b0;
            tick();
            chk_all(d, "abort_idle");
            return;
         end
         w = (flw < 0) ? int'($urandom_range(0, 9)) : flw;
         for (int i = 0; i < w; i++) begin
            wl_v[d]    = 1'($urandom_range(0, 1));
            start_v[d] = 1'($urandom_range(0, 1));
            tick();
            chk_all(d, "fload_hold");
         end
         wl_v[d] = 1'b0; start_v[d] = 1'b0;
         fl_v[d] = 1'b1;
         tick();
         fl_v[d] = 1'b0;
         e_fl = 0;
         if (t < NT[d] - 1) begin
            e_csel[d] = t + 1;
            e_base[d] = (e_base[d] + STRIDE) % 64;
            chk_all(d, "fl_done_mid");
            tick();
            e_fl = 1;
            chk_all(d, "f_next");
         end else begin
            chk_all(d, "fl_done_last");
         end
      end

      for (int i = 0; i < DRAIN - 1; i++) begin
         fl_v[d] = 1'($urandom_range(0, 1));
         tick();
         chk_all(d, "drain");
         if (rst_drain != 0) begin
            fl_v[d] = 1'b0;
            rst = 1'b1;
            #1;
            set_idle();
            for (int k = 0; k < 3; k++) begin
               e_base[k] = BASE0[k];
               e_csel[k] = 0;
            end
            chk_all(d, "rst_async");
            tick();
            chk_all(d, "rst_held");
            rst = 1'b0;
            tick();
            chk_all(d, "rst_idle");
            return;
         end
      end
      fl_v[d] = 1'b0;

      tick();
      e_done = 1;
      chk_all(d, "done");

      // start during the DONE cycle is ignored
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      set_idle();
      chk_all(d, "after_done");
      tick();
      chk_all(d, "idle_stay");
   endtask

   initial begin
      rst = 1'b1;
      start_v = '0; abort_v = '0; wl_v = '0; fl_v = '0;
      set_idle();
      for (int k = 0; k < 3; k++) begin
         e_base[k] = BASE0[k];
         e_csel[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk_all(k, "reset");
      rst = 1'b0;

      run_seq(0, 4, 7, -1, 0);      // directed timing: WL after 5, FL after 8
      run_seq(0, -1, -1, -1, 0);
      run_seq(0, -1, -1, -1, 0);
      run_seq(0, 0, 0, -1, 0);      // minimum-length sequence
      run_seq(0, -1, -1, 2, 0);     // abort during tile-2 pass
      run_seq(0, -1, -1, -1, 0);    // fresh full sequence after abort
      run_seq(0, -1, -1, -1, 1);    // reset during DRAIN
      run_seq(0, -1, -1, -1, 0);
      run_seq(1, -1, -1, -1, 0);    // 62, 1, 4, 7
      run_seq(1, 0, 0, -1, 0);
      run_seq(2, -1, -1, -1, 0);    // single tile
      run_seq(2, 0, 0, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
